snn_weight_store: RTL and testbench

- Weight memory server upstream of the multilayer SNN datapath; answers its two weight-read channels (w_*, wb_*) with a one-cycle valid pulse.
- Contents are loaded byte-serially by the top-level host through a header/data burst loader FSM.
- Flop-based storage of DEPTH words of DW bits; contents persist until the next reset or reload.

---
 rtl/snn_weight_store_if.sv | 30 +++
 rtl/snn_weight_store.sv | 177 +++++++++++++++++
 tb/tb_snn_weight_store.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/snn_weight_store_if.sv
// Bus bundle for snn_weight_store: host byte loader plus the two weight-read channels.
// master = host/datapath side, slave = the weight store.
interface snn_weight_store_if #(
    parameter int ADDR_W = 4,
    parameter int DW     = 8
);
    logic              cfg_valid;
    logic [7:0]        cfg_byte;
    logic              cfg_ready;
    logic              cfg_done;
    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic              w_valid;
    logic [DW-1:0]     w_data;
    logic              wb_req;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_valid;
    logic [DW-1:0]     wb_data;
    logic              busy;

    modport master (
        output cfg_valid, cfg_byte, w_req, w_addr, wb_req, wb_addr,
        input  cfg_ready, cfg_done, w_valid, w_data, wb_valid, wb_data, busy
    );

    modport slave (
        input  cfg_valid, cfg_byte, w_req, w_addr, wb_req, wb_addr,
        output cfg_ready, cfg_done, w_valid, w_data, wb_valid, wb_data, busy
    );
endinterface

// File: rtl/snn_weight_store.sv
// Flop-based weight memory with a header/data byte loader and two latency-1 read ports.
// Optional WSTORE_PARITY_EN adds a per-word even-parity bit and a sticky par_err output.
module snn_weight_store #(
    parameter int ADDR_W = 4,
    parameter int DW     = 8,
    parameter int DEPTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    snn_weight_store_if.slave   bus
`ifdef WSTORE_PARITY_EN
    ,
    output logic                par_err
`endif
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int NCH   = 2;

    typedef enum logic [1:0] {
        L_IDLE,
        L_DATA,
        L_DONE
    } ld_state_t;

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en;

    logic [DW-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0]  word_we;

    // ---------------- loader FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= L_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        wr_en         = 1'b0;
        bus.cfg_ready = 1'b0;
        bus.cfg_done  = 1'b0;
        bus.busy      = 1'b0;
        case (state_q)
            L_IDLE: begin
                bus.cfg_ready = 1'b1;
                if (bus.cfg_valid) begin
                    addr_d  = bus.cfg_byte[ADDR_W-1:0];
                    cnt_d   = {1'b0, bus.cfg_byte[7:4]} + CNT_W'(1);
                    state_d = L_DATA;
                end
            end
            L_DATA: begin
                bus.cfg_ready = 1'b1;
                bus.busy      = 1'b1;
                if (bus.cfg_valid) begin
                    wr_en  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = L_DONE;
                    end
                end
            end
            L_DONE: begin
                bus.cfg_done = 1'b1;
                bus.busy     = 1'b1;
                state_d      = L_IDLE;
            end
            default: state_d = L_IDLE;
        endcase
        // The reset cycle presents an idle, not-ready loader regardless of stale state.
        if (rst) begin
            bus.cfg_ready = 1'b0;
            bus.cfg_done  = 1'b0;
            bus.busy      = 1'b0;
            wr_en         = 1'b0;
        end
    end

    // ---------------- storage ----------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign word_we[gi] = wr_en && (addr_q == ADDR_W'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                mem_q[i] <= '0;
            end else if (word_we[i]) begin
                mem_q[i] <= bus.cfg_byte[DW-1:0];
            end
        end
    end

`ifdef WSTORE_PARITY_EN
    logic [DEPTH-1:0] par_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                par_q[i] <= 1'b0;
            end else if (word_we[i]) begin
                par_q[i] <= ^bus.cfg_byte[DW-1:0];
            end
        end
    end
`endif

    // ---------------- read channels ----------------
    logic              rd_req   [NCH];
    logic [ADDR_W-1:0] rd_addr  [NCH];
    logic [DW-1:0]     rd_word  [NCH];
    logic              rd_bad   [NCH];
    logic              valid_q  [NCH];
    logic [DW-1:0]     data_q   [NCH];

    assign rd_req[0]  = bus.w_req;
    assign rd_addr[0] = bus.w_addr;
    assign rd_req[1]  = bus.wb_req;
    assign rd_addr[1] = bus.wb_addr;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_rd
`ifdef WSTORE_PARITY_EN
        assign rd_bad[gi]  = (^mem_q[rd_addr[gi]]) != par_q[rd_addr[gi]];
`else
        assign rd_bad[gi]  = 1'b0;
`endif
        // Sampling mem_q before the edge gives old-data on a same-cycle write.
        assign rd_word[gi] = rd_bad[gi] ? '0 : mem_q[rd_addr[gi]];

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q[gi] <= 1'b0;
                data_q[gi]  <= '0;
            end else begin
                valid_q[gi] <= rd_req[gi];
                if (rd_req[gi]) begin
                    data_q[gi] <= rd_word[gi];
                end
            end
        end
    end

    assign bus.w_valid  = valid_q[0];
    assign bus.w_data   = data_q[0];
    assign bus.wb_valid = valid_q[1];
    assign bus.wb_data  = data_q[1];

`ifdef WSTORE_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if ((rd_req[0] && rd_bad[0]) || (rd_req[1] && rd_bad[1])) begin
            par_err_q <= 1'b1;
        end
    end

    assign par_err = par_err_q;
`else
    logic unused_rd_bad;
    assign unused_rd_bad = rd_bad[0] | rd_bad[1];
`endif

endmodule

// File: tb/tb_snn_weight_store.sv
// Randomized and directed bench for snn_weight_store against a plain array/loader model.
module tb_snn_weight_store;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snn_weight_store_if #(.ADDR_W(4), .DW(8)) bus ();

`ifdef WSTORE_PARITY_EN
    logic par_err;
    snn_weight_store #(.ADDR_W(4), .DW(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .par_err(par_err)
    );
`else
    snn_weight_store #(.ADDR_W(4), .DW(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model: word array, loader phase (0 idle, 1 data, 2 done), held read data.
    logic [7:0] model [16];
    int         phase;
    int         ld_addr;
    int         ld_left;
    logic [7:0] last_w, last_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (txn %0d)", tag, got, exp, txn);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        phase  = 0;
        ld_addr = 0;
        ld_left = 0;
        last_w = 8'h00;
        last_b = 8'h00;
    endtask

    task automatic drive_idle();
        bus.cfg_valid = 1'b0;
        bus.cfg_byte  = 8'h00;
        bus.w_req     = 1'b0;
        bus.w_addr    = 4'h0;
        bus.wb_req    = 1'b0;
        bus.wb_addr   = 4'h0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        #1;
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        chk("rst_cfg_done",  32'(bus.cfg_done),  32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        #1;
        chk("post_rst_w_valid",   32'(bus.w_valid),   32'd0);
        chk("post_rst_w_data",    32'(bus.w_data),    32'd0);
        chk("post_rst_wb_valid",  32'(bus.wb_valid),  32'd0);
        chk("post_rst_wb_data",   32'(bus.wb_data),   32'd0);
        chk("post_rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("post_rst_busy",      32'(bus.busy),      32'd0);
`ifdef WSTORE_PARITY_EN
        chk("post_rst_par_err",   32'(par_err),       32'd0);
`endif
        $display("txn %0d reset", txn);
        txn++;
    endtask

    // One clock cycle of stimulus; expectations come from the model before it advances.
    task automatic step(input bit cv, input logic [7:0] cb,
                        input bit wr, input logic [3:0] wa,
                        input bit br, input logic [3:0] ba);
        logic [7:0] exp_w, exp_b;
        bus.cfg_valid = cv;
        bus.cfg_byte  = cb;
        bus.w_req     = wr;
        bus.w_addr    = wa;
        bus.wb_req    = br;
        bus.wb_addr   = ba;
        exp_w = wr ? model[wa] : last_w;
        exp_b = br ? model[ba] : last_b;
        case (phase)
            0: if (cv) begin
                ld_addr = int'(cb[3:0]);
                ld_left = int'(cb[7:4]) + 1;
                phase   = 1;
            end
            1: if (cv) begin
                model[ld_addr] = cb;
                ld_addr = (ld_addr + 1) % 16;
                ld_left = ld_left - 1;
                if (ld_left == 0) phase = 2;
            end
            default: phase = 0;
        endcase
        @(posedge clk);
        #1;
        drive_idle();
        chk("w_valid",   32'(bus.w_valid),   32'(wr));
        chk("w_data",    32'(bus.w_data),    32'(exp_w));
        chk("wb_valid",  32'(bus.wb_valid),  32'(br));
        chk("wb_data",   32'(bus.wb_data),   32'(exp_b));
        chk("cfg_done",  32'(bus.cfg_done),  32'(phase == 2));
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(phase != 2));
        chk("busy",      32'(bus.busy),      32'(phase != 0));
`ifdef WSTORE_PARITY_EN
        chk("par_err",   32'(par_err),       32'd0);
`endif
        $display("txn %0d cv=%0b cb=%02h wr=%0b wa=%0d wd=%02h br=%0b ba=%0d bd=%02h done=%0b",
                 txn, cv, cb, wr, wa, bus.w_data, br, ba, bus.wb_data, bus.cfg_done);
        last_w = exp_w;
        last_b = exp_b;
        txn++;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0, 4'h0, 1'b0, 4'h0);
    endtask

    task automatic rd_a(input logic [3:0] a);
        step(1'b0, 8'h00, 1'b1, a, 1'b0, 4'h0);
    endtask

    initial begin
        do_reset();

        // Reset then read address 3.
        rd_a(4'd3);
        chk("rst_read_addr3", 32'(bus.w_data), 32'h00);

        // Burst load two bytes at address 2; done pulses after the last byte.
        send(8'h12);
        send(8'hA5);
        send(8'h3C);
        chk("burst_done_pulse", 32'(bus.cfg_done), 32'd1);
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0);
        rd_a(4'd2);
        chk("burst_addr2", 32'(bus.w_data), 32'hA5);
        rd_a(4'd3);
        chk("burst_addr3", 32'(bus.w_data), 32'h3C);

        // Wrap-around load starting at address 15.
        send(8'h2F);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0);
        step(1'b0, 8'h00, 1'b1, 4'd15, 1'b1, 4'd0);
        chk("wrap_addr15", 32'(bus.w_data),  32'h11);
        chk("wrap_addr0",  32'(bus.wb_data), 32'h22);
        step(1'b0, 8'h00, 1'b1, 4'd1, 1'b1, 4'd2);
        chk("wrap_addr1",  32'(bus.w_data),  32'h33);
        chk("wrap_addr2_kept", 32'(bus.wb_data), 32'hA5);

        // Dual simultaneous read, then both valids drop.
        send(8'h10);
        send(8'h12);
        send(8'h34);
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0);
        step(1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 4'd1);
        chk("dual_a", 32'(bus.w_data),  32'h12);
        chk("dual_b", 32'(bus.wb_data), 32'h34);
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0);

        // Read/write collision at address 5: old value first, new value next.
        do_reset();
        send(8'h05);
        step(1'b1, 8'h77, 1'b1, 4'd5, 1'b0, 4'h0);
        chk("collide_old", 32'(bus.w_data), 32'h00);
        step(1'b0, 8'h00, 1'b1, 4'd5, 1'b0, 4'h0);
        chk("collide_new", 32'(bus.w_data), 32'h77);

        // Reset mid-burst: no done, memory cleared, next byte is a header.
        send(8'h30);
        send(8'hDE);
        send(8'hAD);
        chk("midburst_busy", 32'(bus.busy), 32'd1);
        do_reset();
        for (int i = 0; i < 16; i += 2) begin
            step(1'b0, 8'h00, 1'b1, 4'(i), 1'b1, 4'(i + 1));
        end
        send(8'h0A);
        send(8'h5A);
        chk("midburst_new_done", 32'(bus.cfg_done), 32'd1);
        step(1'b0, 8'h00, 1'b1, 4'd10, 1'b0, 4'h0);
        chk("midburst_new_word", 32'(bus.w_data), 32'h5A);

        // Randomized traffic: loads, idles and reads on both channels, including collisions.
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 4) != 0, 8'($urandom),
                 ($urandom % 2) == 1, 4'($urandom),
                 ($urandom % 2) == 1, 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
